bfs_axi_rd_arbiter: RTL

- Parametrised N-channel AXI4 read-master arbiter for the BFS accelerator. It lets multiple engines share one m_axi read port: frontier fetch, adjacency fetch, visited-bitmap fetch, and more.
- Round-robin AR arbitration with registered AR output. Tracks up to MAX_OUTSTANDING in-order bursts.
- Routes R beats back to the issuing channel. Checks burst length and RRESP, with per-channel sticky error status.
- Sits between the BFS engines and the AXI4 master port of the accelerator top.

---
 rtl/bfs_axi_pkg.sv | 23 ++
 rtl/bfs_sync_fifo.sv | 51 +++++
 rtl/bfs_axi_rd_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bfs_axi_pkg.sv
// Shared types and helpers for the BFS AXI read arbiter.
package bfs_axi_pkg;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  // Tag channel field is sized for the largest supported channel count (8).
  localparam int unsigned TAG_CH_W = 3;

  function automatic int unsigned CH_W(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [TAG_CH_W-1:0] ch;
    logic [7:0]          len;
  } burst_tag_t;

endpackage

// File: rtl/bfs_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; Depth must be a power of two.
module bfs_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [Width-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [Width-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(Depth):0]   o_count
);

  localparam int unsigned PtrW = (Depth <= 1) ? 1 : $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CntW'(Depth));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/bfs_axi_rd_arbiter.sv
// N-channel round-robin AXI4 read arbiter: registered AR, in-order R routing via a
// tracking FIFO of {channel, len}, with per-channel sticky burst/response error flags.
module bfs_axi_rd_arbiter
  import bfs_axi_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_DATA_WIDTH  = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [NUM_CH-1:0]                  s_arvalid,
  input  logic [NUM_CH*AXI_ADDR_WIDTH-1:0]   s_araddr,
  input  logic [NUM_CH*8-1:0]                s_arlen,
  output logic [NUM_CH-1:0]                  s_arready,
  output logic [NUM_CH-1:0]                  s_rvalid,
  output logic [AXI_DATA_WIDTH-1:0]          s_rdata,
  output logic                               s_rlast,
  output logic [1:0]                         s_rresp,
  input  logic [NUM_CH-1:0]                  s_rready,
  output logic [AXI_ADDR_WIDTH-1:0]          m_axi_araddr,
  output logic [7:0]                         m_axi_arlen,
  output logic                               m_axi_arvalid,
  input  logic                               m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]          m_axi_rdata,
  input  logic                               m_axi_rlast,
  input  logic [1:0]                         m_axi_rresp,
  input  logic                               m_axi_rvalid,
  output logic                               m_axi_rready,
  output logic [NUM_CH-1:0]                  err_status,
  input  logic [NUM_CH-1:0]                  err_clr,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

  localparam int unsigned ChW    = CH_W(NUM_CH);
  localparam logic [ChW-1:0] LastCh = ChW'(NUM_CH - 1);

  logic                      r_arvalid;
  logic [AXI_ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]                r_arlen;
  logic [ChW-1:0]            r_rr_ptr;
  logic [7:0]                r_beat_cnt;
  logic [NUM_CH-1:0]         r_err;

  logic                      w_found_hi, w_found_lo, w_grant;
  logic [ChW-1:0]            w_idx_hi, w_idx_lo, w_grant_idx;
  logic [AXI_ADDR_WIDTH-1:0] w_sel_addr;
  logic [7:0]                w_sel_len;
  burst_tag_t                w_push_tag, w_head;
  logic                      w_empty, w_full, w_hs, w_pop, w_bad;
  logic [NUM_CH-1:0]         w_err_set;

  // Two-pass priority search: first requester at/after the pointer, else the lowest one.
  always_comb begin
    w_found_hi = 1'b0;
    w_idx_hi   = '0;
    w_found_lo = 1'b0;
    w_idx_lo   = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (s_arvalid[i] && (ChW'(i) >= r_rr_ptr) && !w_found_hi) begin
        w_found_hi = 1'b1;
        w_idx_hi   = ChW'(i);
      end
      if (s_arvalid[i] && !w_found_lo) begin
        w_found_lo = 1'b1;
        w_idx_lo   = ChW'(i);
      end
    end
    w_grant_idx = w_found_hi ? w_idx_hi : w_idx_lo;
  end

  // Full is judged on the pre-pop count, so a retiring burst frees a slot one cycle later.
  assign w_grant = (~r_arvalid | m_axi_arready) & ~w_full & (|s_arvalid);

  always_comb begin
    s_arready  = '0;
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (w_grant_idx == ChW'(i)) begin
        s_arready[i] = w_grant;
        w_sel_addr   = s_araddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        w_sel_len    = s_arlen[i*8 +: 8];
      end
    end
  end

  assign w_push_tag.ch  = TAG_CH_W'(w_grant_idx);
  assign w_push_tag.len = w_sel_len;

  bfs_sync_fifo #(
    .Width ($bits(burst_tag_t)),
    .Depth (MAX_OUTSTANDING)
  ) u_track_fifo (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_push  (w_grant),
    .i_wdata (w_push_tag),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (outstanding)
  );

  assign w_hs  = m_axi_rvalid & m_axi_rready;
  assign w_pop = w_hs & m_axi_rlast;
  assign w_bad = (m_axi_rresp != AXI_RESP_OKAY) ||
                 ( m_axi_rlast && (r_beat_cnt != w_head.len)) ||
                 (!m_axi_rlast && (r_beat_cnt == w_head.len));

  always_comb begin
    s_rvalid     = '0;
    m_axi_rready = 1'b0;
    w_err_set    = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (w_head.ch == TAG_CH_W'(i)) begin
        s_rvalid[i]  = m_axi_rvalid & ~w_empty;
        m_axi_rready = ~w_empty & s_rready[i];
        w_err_set[i] = w_hs & w_bad;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_arvalid  <= 1'b0;
      r_araddr   <= '0;
      r_arlen    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_err      <= '0;
    end else begin
      if (w_grant) begin
        r_arvalid <= 1'b1;
        r_araddr  <= w_sel_addr;
        r_arlen   <= w_sel_len;
        r_rr_ptr  <= (w_grant_idx == LastCh) ? '0 : w_grant_idx + 1'b1;
      end else if (m_axi_arready) begin
        r_arvalid <= 1'b0;
      end
      if (w_hs) r_beat_cnt <= m_axi_rlast ? 8'd0 : r_beat_cnt + 8'd1;
      r_err <= (r_err & ~err_clr) | w_err_set;
    end
  end

  assign m_axi_arvalid = r_arvalid;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = r_arlen;
  assign s_rdata       = m_axi_rdata;
  assign s_rlast       = m_axi_rlast;
  assign s_rresp       = m_axi_rresp;
  assign err_status    = r_err;

endmodule
